// File: rtl/imem_responder_if.sv
// Fetch-side request/response bundle between the fetch stage and imem_responder.
// master = fetch stage (initiator), slave = instruction memory responder.
interface imem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic [31:0]           req_addr;
  logic                  req_ready;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic                  resp_ready;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Single-outstanding instruction memory responder with LATENCY wait states and a preload port.
// Define IMEM_BOUNDS_CHECK_EN to flag misaligned/out-of-range fetches on resp_err and drop such loads.
module imem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 6,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_responder_if.slave       bus,
  input  logic                  ld_en,
  input  logic [31:0]           ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [31:0]           addr_reg;
  logic [DATA_WIDTH-1:0] resp_data_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic [31:0]           rd_addr;
  logic [ADDR_BITS-1:0]  rd_idx;
  logic [ADDR_BITS-1:0]  ld_idx;

  assign bus.req_ready  = (state_reg == IDLE) && !reset;
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_data  = resp_data_reg;
  assign accept         = bus.req_valid && bus.req_ready;

  // With zero wait states the read happens on the accept edge, so the live address is used.
  assign rd_addr = (state_reg == IDLE) ? bus.req_addr : addr_reg;
  assign rd_idx  = rd_addr[ADDR_BITS+1:2];
  assign ld_idx  = ld_addr[ADDR_BITS+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic resp_err_reg;
  logic rd_bad;
  logic ld_bad;
  assign rd_bad       = (rd_addr[1:0] != 2'b00) || (rd_addr[31:ADDR_BITS+2] != '0);
  assign ld_bad       = (ld_addr[1:0] != 2'b00) || (ld_addr[31:ADDR_BITS+2] != '0);
  assign bus.resp_err = resp_err_reg;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[1:0], rd_addr[31:ADDR_BITS+2],
                              ld_addr[1:0], ld_addr[31:ADDR_BITS+2]};
  assign bus.resp_err     = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg <= bus.req_addr;
      end
    end
  end

  // Registered read; a same-edge load to the same word lands after this sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data_reg <= '0;
`ifdef IMEM_BOUNDS_CHECK_EN
      resp_err_reg  <= 1'b0;
`endif
    end else if (enter_resp) begin
`ifdef IMEM_BOUNDS_CHECK_EN
      resp_err_reg  <= rd_bad;
      resp_data_reg <= rd_bad ? '0 : mem[rd_idx];
`else
      resp_data_reg <= mem[rd_idx];
`endif
    end
  end

  // Preload port is deliberately outside reset so boot code can load while reset is held.
  always_ff @(posedge clk) begin
`ifdef IMEM_BOUNDS_CHECK_EN
    if (ld_en && !ld_bad) begin
      mem[ld_idx] <= ld_data;
    end
`else
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
`endif
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the far side of the fetch stage's instruction-read interface.
- Accepts one word-aligned fetch request at a time over a valid/ready handshake and returns the 32-bit instruction after a fixed, parameterised number of wait states.
- Holds the response until the fetch side accepts it.
- A side load port lets the bench or boot logic preload program words.

Parameters:
- DATA_WIDTH, 32, instruction/word width in bits.
- ADDR_BITS, 6, word-index bits; depth = 2**ADDR_BITS words (64).
- LATENCY, 1, wait-state cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_addr  input  32  byte address of requested instruction (PC value).
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  resp_data/resp_err are valid.
- resp_data  output  DATA_WIDTH  instruction word.
- resp_err  output  1  bad-address flag (see Optional Feature).
- resp_ready  input  1  fetch side accepts the response.
- ld_en  input  1  write enable for the preload port.
- ld_addr  input  32  byte address for the preload write.
- ld_data  input  DATA_WIDTH  preload data.

Behaviour:
- Reset: synchronous, active-high; the polarity and synchronicity are fixed.
  - On reset: state=IDLE, resp_valid=0, resp_data=0, resp_err=0, wait counter=0.
  - req_ready=0 while reset is high.
  - Memory contents are not cleared by reset.
  - Reset mid-transaction discards the pending request; no response is issued.
- Word index = addr[ADDR_BITS+1:2]. Bits [1:0] and bits above ADDR_BITS+1 are ignored unless the feature is enabled.
- FSM has states IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1 (combinational from state, gated by reset).
  - req_valid & req_ready at edge T0 captures req_addr.
  - If LATENCY=0, go to RESP. Otherwise go to WAIT and load counter=LATENCY.
- WAIT:
  - req_ready=0; counter decrements each edge.
  - When counter==1 at an edge, go to RESP.
- Response timing:
  - resp_valid first high in the cycle after edge T0+LATENCY.
  - Latency, accept edge to first resp_valid cycle, is LATENCY+1 cycles.
- Read sampling: the memory is read at the edge entering RESP.
  - ld writes completed at earlier edges are visible.
  - A ld write to the same word at that same edge is not visible (read-before-write).
- RESP:
  - req_ready=0. resp_valid=1, and resp_data/resp_err are held stable until resp_valid & resp_ready.
  - On the handshake edge: resp_valid=0, return to IDLE. resp_data holds its last value.
  - Back-pressure of any length is legal.
- Throughput: at most one request per LATENCY+2 cycles.
- Requests are never dropped or reordered. req_valid while req_ready=0 is ignored; the initiator must hold it.
- Load port:
  - ld_en writes mem[ld_addr word index] <= ld_data at the edge.
  - Permitted in any state, including during reset.
  - Independent of the request handshake.

Optional Feature:
- Macro: IMEM_BOUNDS_CHECK_EN.
- Defined:
  - A captured address with addr[1:0]!=0, or any bit of addr[31:ADDR_BITS+2] set, produces resp_err=1 and resp_data=0.
  - Latency and handshake are identical to the normal case; the memory is not read.
  - ld writes to such addresses are dropped.
- Undefined:
  - resp_err is tied 0.
  - Out-of-range addresses alias via the word index; misaligned low bits are ignored.

Test Plan:
1. Reset, then check outputs: after 1 reset cycle, req_ready=1, resp_valid=0, resp_data=0 → pass.
2. Preload then read with LATENCY=1:
   - Preload: ld word 0x10 (byte address 0x40) = 0x8C220004.
   - Request: req_addr=0x40 accepted at edge T0.
   - Required: resp_valid high in the cycle after edge T0+1, resp_data=0x8C220004; req_ready=0 until the response handshake.
3. Back-pressure:
   - Stimulus: resp_ready=0 for 5 cycles after resp_valid rises, then 1.
   - Required: resp_valid and resp_data stable all 5 cycles; IDLE and req_ready=1 the cycle after the handshake.
4. LATENCY=0 and LATENCY=3 builds, resp_ready tied 1: requests 0x00, 0x04, 0x08 issued as soon as req_ready allows → accept-to-first-resp_valid = 1 and 4 cycles respectively; data order preserved.
5. Collision and reset:
   - ld to the word being read at the edge entering RESP → old data returned. The next read of that word → new data.
   - Reset asserted during WAIT → no response; req_ready=1 after reset drops.
6. IMEM_BOUNDS_CHECK_EN defined, ADDR_BITS=6:
   - req_addr=0x102 (misaligned) → resp_err=1, resp_data=0.
   - req_addr=0x100 (out of range) → resp_err=1.
   - req_addr=0xFC → resp_err=0 with valid data.
   - Without the macro, req_addr=0x100 returns word 0 and resp_err=0.
